// File: rtl/ssd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ssd_pkg                                                              |
// | Glyph table, error-bit indices and glyph decode for ssd_decoder.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ssd_pkg;

    // Active-low segment patterns (g..a) for hex digits 0..F.
    localparam logic [6:0] c_glyph_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        ERR_GLYPH    = 2'd0,
        ERR_MULTI    = 2'd1,
        ERR_CONFLICT = 2'd2
    } err_bit_e;

    // Returns {legal, nibble}; an unknown pattern yields {0, 4'h0}.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b0;
        for (int k = 0; k < 16; k++) begin
            if (seg == c_glyph_table[k]) begin
                res = {1'b1, 4'(k)};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_stability_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ssd_stability_filter                                                 |
// | Registers the display bus and strobes once per stable sample.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ssd_stability_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_anode,
    input  logic [7:0] i_segment,
    output logic       o_accept,
    output logic [3:0] o_anode,
    output logic [7:0] o_segment
);

    localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);
    localparam logic [3:0] c_pre    = 4'(STABLE_CYCLES - 1);

    logic [11:0] r_sample;
    logic [11:0] r_prev;
    logic [3:0]  r_cnt;
    logic        r_accept;
    logic        w_same;

    assign w_same = (r_sample == r_prev);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= 12'd0;
            r_prev   <= 12'd0;
            r_cnt    <= 4'd0;
            r_accept <= 1'b0;
        end else begin
            r_sample <= {i_anode, i_segment};
            r_prev   <= r_sample;
            if (!w_same) begin
                r_cnt <= 4'd0;
            end else if (r_cnt != c_stable) begin
                r_cnt <= r_cnt + 4'd1;
            end
            // Strobe on the transition into saturation only.
            r_accept <= w_same && (r_cnt == c_pre);
        end
    end

    // r_prev still holds the stable value even if the bus moved this cycle.
    assign o_accept  = r_accept;
    assign o_anode   = r_prev[11:8];
    assign o_segment = r_prev[7:0];

endmodule
`default_nettype wire

// File: rtl/ssd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ssd_decoder                                                          |
// | Recovers the hex value shown on a scanned 4-digit 7-segment display. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ssd_decoder
    import ssd_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int WINDOW_BITS   = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [7:0]  segment,
    output logic [15:0] data_out,
    output logic [3:0]  enabled_dig,
    output logic [3:0]  point_out,
    output logic [2:0]  error_out,
    output logic        frame_valid
);

    logic                   w_accept;
    logic [3:0]             w_acc_anode;
    logic [7:0]             w_acc_segment;

    logic [WINDOW_BITS-1:0] r_win;
    logic [3:0][3:0]        r_nib;
    logic [3:0]             r_point;
    logic [3:0]             r_seen;
    logic [2:0]             r_flags;

    logic [15:0]            r_data_out;
    logic [3:0]             r_enabled_dig;
    logic [3:0]             r_point_out;
    logic [2:0]             r_error_out;
    logic                   r_frame_valid;

    logic [3:0]             w_low;
    logic                   w_one_hot;
    logic [1:0]             w_idx;
    logic [4:0]             w_dec;
    logic [3:0]             w_new_nib;
    logic                   w_new_pt;
    logic [3:0][3:0]        w_nib;
    logic [3:0][3:0]        w_masked;
    logic [3:0]             w_point;
    logic [3:0]             w_seen;
    logic [2:0]             w_flags;
    logic                   w_win_end;

    ssd_stability_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .i_anode   (anode),
        .i_segment (segment),
        .o_accept  (w_accept),
        .o_anode   (w_acc_anode),
        .o_segment (w_acc_segment)
    );

    assign w_low     = ~w_acc_anode;
    assign w_one_hot = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_dec     = glyph_decode(w_acc_segment[6:0]);
    assign w_new_nib = w_dec[4] ? w_dec[3:0] : 4'h0;
    assign w_new_pt  = ~w_acc_segment[7];
    assign w_win_end = &r_win;

    always_comb begin
        w_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (w_low[k]) begin
                w_idx = 2'(k);
            end
        end
    end

    // Next accumulator state; folded straight into the frame at window end.
    always_comb begin
        w_nib   = r_nib;
        w_point = r_point;
        w_seen  = r_seen;
        w_flags = r_flags;
        if (w_accept && w_one_hot) begin
            if (r_seen[w_idx] && ((r_nib[w_idx] != w_new_nib) || (r_point[w_idx] != w_new_pt))) begin
                w_flags[ERR_CONFLICT] = 1'b1;
            end
            if (!w_dec[4]) begin
                w_flags[ERR_GLYPH] = 1'b1;
            end
            w_nib[w_idx]   = w_new_nib;
            w_point[w_idx] = w_new_pt;
            w_seen[w_idx]  = 1'b1;
        end else if (w_accept && (w_low != 4'd0)) begin
            w_flags[ERR_MULTI] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            w_masked[k] = w_seen[k] ? w_nib[k] : 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win         <= '0;
            r_nib         <= '0;
            r_point       <= 4'd0;
            r_seen        <= 4'd0;
            r_flags       <= 3'd0;
            r_data_out    <= 16'd0;
            r_enabled_dig <= 4'd0;
            r_point_out   <= 4'd0;
            r_error_out   <= 3'd0;
            r_frame_valid <= 1'b0;
        end else begin
            r_win         <= r_win + 1'b1;
            r_frame_valid <= 1'b0;
            if (w_win_end) begin
                r_data_out    <= w_masked;
                r_enabled_dig <= w_seen;
                r_point_out   <= w_point & w_seen;
                r_error_out   <= w_flags;
                r_frame_valid <= 1'b1;
                r_nib         <= '0;
                r_point       <= 4'd0;
                r_seen        <= 4'd0;
                r_flags       <= 3'd0;
            end else begin
                r_nib   <= w_nib;
                r_point <= w_point;
                r_seen  <= w_seen;
                r_flags <= w_flags;
            end
        end
    end

    assign data_out    = r_data_out;
    assign enabled_dig = r_enabled_dig;
    assign point_out   = r_point_out;
    assign error_out   = r_error_out;
    assign frame_valid = r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_ssd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ssd_decoder                                                       |
// | Scoreboard bench: run-length reference model vs. ssd_decoder.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ssd_decoder;

    localparam int STABLE_CYCLES = 4;
    localparam int WINDOW_BITS   = 6;
    localparam int WIN           = 1 << WINDOW_BITS;
    localparam logic [11:0] c_idle = 12'hFFF;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  en;
        logic [3:0]  pt;
        logic [2:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  anode = 4'hF;
    logic [7:0]  segment = 8'hFF;
    logic [15:0] data_out;
    logic [3:0]  enabled_dig;
    logic [3:0]  point_out;
    logic [2:0]  error_out;
    logic        frame_valid;

    int total = 0;
    int bad   = 0;

    frame_t      exp_q[$];
    logic [11:0] win_stream [WIN];
    logic [6:0]  glyph_tbl  [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    ssd_decoder #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .WINDOW_BITS   (WINDOW_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .anode       (anode),
        .segment     (segment),
        .data_out    (data_out),
        .enabled_dig (enabled_dig),
        .point_out   (point_out),
        .error_out   (error_out),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: every run of identical bus samples lasting at least
    // STABLE_CYCLES+1 cycles is one accepted sample.
    task automatic model_window(output frame_t f);
        logic [3:0] nib [4];
        bit         seen [4];
        bit         pt [4];
        bit [2:0]   err;
        int         p, q, zeros, idx, n;
        bit         legal;
        logic [3:0] a;
        logic [7:0] s;
        for (int k = 0; k < 4; k++) begin
            nib[k] = 4'h0; seen[k] = 1'b0; pt[k] = 1'b0;
        end
        err = 3'b000;
        p = 0;
        while (p < WIN) begin
            q = p;
            while (q < WIN && win_stream[q] == win_stream[p]) q++;
            if (q - p >= STABLE_CYCLES + 1) begin
                a = win_stream[p][11:8];
                s = win_stream[p][7:0];
                zeros = 0; idx = 0;
                for (int k = 0; k < 4; k++) if (!a[k]) begin zeros++; idx = k; end
                if (zeros == 1) begin
                    legal = 1'b0; n = 0;
                    for (int g = 0; g < 16; g++) if (glyph_tbl[g] == s[6:0]) begin legal = 1'b1; n = g; end
                    if (!legal) err[0] = 1'b1;
                    if (seen[idx] && (nib[idx] != 4'(n) || pt[idx] != !s[7])) err[2] = 1'b1;
                    nib[idx] = 4'(n); pt[idx] = !s[7]; seen[idx] = 1'b1;
                end else if (zeros > 1) begin
                    err[1] = 1'b1;
                end
            end
            p = q;
        end
        f = '0;
        for (int k = 0; k < 4; k++) begin
            f.data[4*k +: 4] = seen[k] ? nib[k] : 4'h0;
            f.en[k] = seen[k];
            f.pt[k] = seen[k] && pt[k];
        end
        f.err = err;
    endtask

    task automatic clear_window();
        for (int k = 0; k < WIN; k++) win_stream[k] = c_idle;
    endtask

    task automatic set_run(input int p, input int len, input logic [11:0] v);
        for (int k = p; k < p + len && k < WIN; k++) win_stream[k] = v;
    endtask

    // Drives window positions 0..npos-1, one per cycle, starting at a window boundary.
    task automatic play_window(input int npos, input bit push);
        frame_t f;
        if (push) begin
            model_window(f);
            exp_q.push_back(f);
        end
        for (int p = 0; p < npos; p++) begin
            {anode, segment} = win_stream[p];
            @(negedge clk);
        end
    endtask

    function automatic logic [11:0] rand_value();
        logic [3:0] a;
        logic [7:0] s;
        int r, d0, d1;
        r = $urandom_range(0, 7);
        d0 = $urandom_range(0, 3);
        if (r == 5) a = 4'hF;
        else if (r == 6) begin
            d1 = (d0 + $urandom_range(1, 3)) % 4;
            a = ~((4'd1 << d0) | (4'd1 << d1));
        end else a = ~(4'd1 << d0);
        s[7] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0) s[6:0] = glyph_tbl[$urandom_range(0, 15)];
        else s[6:0] = 7'($urandom);
        return {a, s};
    endfunction

    task automatic random_window();
        int p, len;
        logic [11:0] prev, v;
        clear_window();
        p = 2;
        prev = c_idle;
        while (p <= 50) begin
            v = rand_value();
            while (v == prev) v = rand_value();
            len = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : $urandom_range(6, 12);
            set_run(p, len, v);
            p += len;
            prev = v;
        end
    endtask

    // Monitor: pop and compare on every published frame.
    always @(posedge clk) begin
        frame_t f;
        #1;
        if (frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                f = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(f.data));
                check("enabled_dig", 32'(enabled_dig), 32'(f.en));
                check("point_out", 32'(point_out), 32'(f.pt));
                check("error_out", 32'(error_out), 32'(f.err));
            end
        end
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data_out), 32'd0);
        check("reset_en", 32'(enabled_dig), 32'd0);
        check("reset_valid", 32'(frame_valid), 32'd0);
        reset = 1'b0;

        // Digit 0 shows 0, dp off.
        clear_window(); set_run(2, 10, {4'b1110, 8'b11000000}); play_window(WIN, 1'b1);
        // Too short to be accepted.
        clear_window(); set_run(2, 3, {4'b1101, 8'b11111001}); play_window(WIN, 1'b1);
        // Two anodes low.
        clear_window(); set_run(2, 8, {4'b1100, 8'b11000000}); play_window(WIN, 1'b1);
        // Illegal glyph on digit 1.
        clear_window(); set_run(2, 8, {4'b1101, 8'b10111111}); play_window(WIN, 1'b1);
        // Digit 1 shows 2 then 7.
        clear_window(); set_run(2, 8, {4'b1101, 8'b10100100});
        set_run(10, 8, {4'b1101, 8'b11111000}); play_window(WIN, 1'b1);
        // Full scan 3, C, 5, A with dp on digit 2.
        clear_window();
        set_run(0, 16, {4'b1110, 8'b10110000});
        set_run(16, 16, {4'b1101, 8'b11000110});
        set_run(32, 16, {4'b1011, 8'b00010010});
        set_run(48, 16, {4'b0111, 8'b10001000});
        play_window(WIN, 1'b1);

        // Mid-window reset at count 40 discards the partial window.
        clear_window(); set_run(2, 10, {4'b1110, 8'b10000000});
        play_window(40, 1'b0);
        reset = 1'b1;
        {anode, segment} = c_idle;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_en", 32'(enabled_dig), 32'd0);
        check("rst_pt", 32'(point_out), 32'd0);
        check("rst_err", 32'(error_out), 32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        reset = 1'b0;
        clear_window();
        cyc = 1;
        fork
            play_window(WIN, 1'b1);
            begin
                for (int k = 0; k < 200; k++) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (frame_valid === 1'b1) break;
                end
            end
        join
        check("rst_to_frame_cycles", 32'(cyc), 32'(WIN + 1));

        for (int w = 0; w < 12; w++) begin
            random_window();
            play_window(WIN, 1'b1);
        end
        clear_window();
        for (int k = 0; k < 3 * WIN && exp_q.size() != 0; k++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
